// File: rtl/fetch_prefetch_queue_pkg.sv
// Constants shared by the fetch front end: default reset PC, NOP encoding and
// the width of occupancy/credit counters for a given queue depth.
package fetch_prefetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// prefetch_fifo: power-of-two circular buffer with push, pop, clear and
// full/empty/count status. Clear wins over a same-cycle push or pop.
module prefetch_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  logic                          clear_i,
    input  logic [WIDTH-1:0]              wdata_i,
    output logic [WIDTH-1:0]              rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited imem reads
// and squashes wrong-path beats after redirects. `PREFETCH_BYPASS_EN enables the
// same-cycle response bypass into an empty queue.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic        stall_f,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        valid_f,
    output logic [31:0] instruction_f,
    output logic [31:0] pc_plus_4_f
);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] occupancy, outstanding, outstanding_d;
    logic          q_full, q_empty, a_full, a_empty;
    logic [63:0]   q_head;
    logic [31:0]   a_head;
    logic          hs, rsp, squash, accept, push, pop;

    // Queued entries plus in-flight reads never exceed DEPTH, so a beat always has room.
    assign imem_req_valid = reset_n && !pc_src_d && !a_full && !q_full &&
                            (({1'b0, occupancy} + {1'b0, outstanding}) < CREDITS);
    assign imem_req_addr  = pc_q;
    assign hs             = imem_req_valid && imem_req_ready;
    assign rsp            = imem_rsp_valid && !a_empty;
    assign squash         = (discard_q != '0) || pc_src_d;
    assign accept         = rsp && !squash;
    assign pop            = !q_empty && !stall_f;
    // The address FIFO holds exactly one entry per outstanding read.
    assign outstanding_d  = outstanding + CW'(hs) - CW'(rsp);

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass = accept && q_empty && !stall_f;
    assign push   = accept && !bypass;
`else
    assign push   = accept;
`endif

    always_comb begin
        valid_f       = !q_empty;
        instruction_f = q_empty ? NOP_INSTR : q_head[63:32];
        pc_plus_4_f   = q_empty ? 32'h0 : q_head[31:0];
`ifdef PREFETCH_BYPASS_EN
        if (bypass) begin
            valid_f       = 1'b1;
            instruction_f = imem_rsp_data;
            pc_plus_4_f   = a_head + 32'd4;
        end
`endif
    end

    always_comb begin
        pc_d      = pc_q;
        discard_d = discard_q;
        if (hs) pc_d = pc_q + 32'd4;
        if (rsp && discard_q != '0) discard_d = discard_q - CW'(1);
        // Everything still in flight after this edge belongs to the old path.
        if (pc_src_d) begin
            pc_d      = {pc_branch_d[31:2], 2'b00};
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_data_q (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (pc_src_d),
        .wdata_i ({imem_rsp_data, a_head + 32'd4}),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (occupancy)
    );

    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_addr_q (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (hs),
        .pop_i   (rsp),
        .clear_i (1'b0),
        .wdata_i (pc_q),
        .rdata_o (a_head),
        .full_o  (a_full),
        .empty_o (a_empty),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: constant-table start-up/stall sequence, directed
// redirect/reset/bypass sequences, and random traffic against a queue-based model.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] R     = 32'h0040_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, pc_src_d, stall_f, imem_req_valid, imem_req_ready, imem_rsp_valid, valid_f;
    logic [31:0] pc_branch_d, imem_req_addr, imem_rsp_data, instruction_f, pc_plus_4_f;

    always #5 clock = ~clock;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(R)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pc_src_d       (pc_src_d),
        .pc_branch_d    (pc_branch_d),
        .stall_f        (stall_f),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_f        (valid_f),
        .instruction_f  (instruction_f),
        .pc_plus_4_f    (pc_plus_4_f)
    );

    typedef struct packed { logic [31:0] ins; logic [31:0] p4; } ent_t;
    typedef struct packed { logic [31:0] addr; int due; } mreq_t;
    typedef struct packed { logic st; logic rv; logic [31:0] ra; logic vf; logic [31:0] p4; } vec_t;

    int          errors = 0, checks = 0, cyc = 0, mem_lat = 1, o_cyc;
    mreq_t       mem_q[$];
    ent_t        m_q[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_pc = R;
    int          m_disc = 0;
    logic        o_rv, o_vf;
    logic [31:0] o_addr, o_ins, o_p4;
    vec_t        vt[19];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hC0DE_5A11;
    endfunction

    function automatic logic [127:0] pack(input logic rv, input logic [31:0] ad, input logic vf,
                                          input logic [31:0] ins, input logic [31:0] p4);
        return {30'b0, rv, ad, vf, ins, p4};
    endfunction

    function automatic vec_t mk(input logic st, input logic rv, input int ra, input logic vf, input int p4);
        vec_t v;
        v.st = st; v.rv = rv; v.ra = R + 32'(ra); v.vf = vf;
        v.p4 = vf ? R + 32'(p4) : 32'h0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; stall_f = 1'b0; pc_src_d = 1'b0; pc_branch_d = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        mem_q.delete(); m_q.delete(); m_infl.delete(); m_pc = R; m_disc = 0;
        #1;
        chk("reset_outputs", pack(imem_req_valid, imem_req_addr, valid_f, instruction_f, pc_plus_4_f),
            pack(1'b0, R, 1'b0, 32'h0, 32'h0));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        cyc = 0;
    endtask

    // One clock: drive inputs and memory response, compare against the model, advance both.
    task automatic step(input logic st, input logic ps, input logic [31:0] br, input logic rdy);
        logic e_rv, e_vf, byp;
        logic [31:0] e_ins, e_p4, a;
        @(negedge clock);
        stall_f = st; pc_src_d = ps; pc_branch_d = br; imem_req_ready = rdy;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom();
        end
        #1;
        o_cyc = cyc; o_rv = imem_req_valid; o_addr = imem_req_addr;
        o_vf = valid_f; o_ins = instruction_f; o_p4 = pc_plus_4_f;

        e_rv = !ps && (m_q.size() + m_infl.size() < DEPTH);
        byp  = 1'b0;
`ifdef PREFETCH_BYPASS_EN
        byp = imem_rsp_valid && m_infl.size() > 0 && m_disc == 0 && !ps && !st && m_q.size() == 0;
`endif
        if (byp) begin
            e_vf = 1'b1; e_ins = memf(m_infl[0]); e_p4 = m_infl[0] + 32'd4;
        end else if (m_q.size() > 0) begin
            e_vf = 1'b1; e_ins = m_q[0].ins; e_p4 = m_q[0].p4;
        end else begin
            e_vf = 1'b0; e_ins = 32'h0; e_p4 = 32'h0;
        end
        chk("model", pack(o_rv, o_addr, o_vf, o_ins, o_p4), pack(e_rv, m_pc, e_vf, e_ins, e_p4));

        if (o_rv && rdy) mem_q.push_back('{imem_req_addr, cyc + mem_lat});
        if (m_q.size() > 0 && !st) void'(m_q.pop_front());
        if (imem_rsp_valid && m_infl.size() > 0) begin
            a = m_infl.pop_front();
            if (m_disc > 0) m_disc--;
            else if (!ps && !byp) m_q.push_back('{memf(a), a + 32'd4});
        end
        if (e_rv && rdy) begin
            m_infl.push_back(m_pc);
            m_pc += 32'd4;
        end
        if (ps) begin
            m_q.delete();
            m_pc   = {br[31:2], 2'b00};
            m_disc = m_infl.size();
        end
        cyc++;
    endtask

    // Run unstalled until valid_f appears (bounded) and check which entry surfaces first.
    task automatic run_until_valid(input string nm, input int exp_cyc, input logic [31:0] exp_p4);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (o_vf) begin
                seen = 1'b1;
                if (exp_cyc >= 0) chk({nm, "_cycle"}, 128'(o_cyc), 128'(exp_cyc));
                chk({nm, "_head"}, {64'h0, o_p4, o_ins}, {64'h0, exp_p4, memf(exp_p4 - 32'd4)});
            end
        end
        chk({nm, "_seen"}, 128'(seen), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic        st, ps, rdy;
        logic [31:0] br;
        reset_n = 1'b0; stall_f = 1'b0; pc_src_d = 1'b0; pc_branch_d = 32'h0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Start-up with 1-cycle memory, then a 10-cycle stall that fills the queue.
        vt[0] = mk(0, 1, 0, 0, 0);
        vt[1] = mk(0, 1, 4, 0, 0);
        vt[2] = mk(0, 1, 8, 1, 4);
        vt[3] = mk(0, 1, 12, 1, 8);
        vt[4] = mk(1, 1, 16, 1, 12);
        vt[5] = mk(1, 1, 20, 1, 12);
        for (int i = 6; i < 14; i++) vt[i] = mk(1, 0, 24, 1, 12);
        vt[14] = mk(0, 0, 24, 1, 12);
        vt[15] = mk(0, 1, 24, 1, 16);
        vt[16] = mk(0, 1, 28, 1, 20);
        vt[17] = mk(0, 1, 32, 1, 24);
        vt[18] = mk(0, 1, 36, 1, 28);

        do_reset();
        mem_lat = 1;
`ifndef PREFETCH_BYPASS_EN
        foreach (vt[i]) begin
            step(vt[i].st, 1'b0, 32'h0, 1'b1);
            chk($sformatf("table[%0d]", i), pack(o_rv, o_addr, o_vf, o_ins, o_p4),
                pack(vt[i].rv, vt[i].ra, vt[i].vf, vt[i].vf ? memf(vt[i].p4 - 32'd4) : 32'h0, vt[i].p4));
        end
`endif

        // First response after reset: bypass shows it in the same cycle.
        do_reset();
        mem_lat = 1;
        run_until_valid("first_fetch", 2 - BYP, R + 32'd4);

        // Redirect with three reads in flight on a 3-cycle memory.
        do_reset();
        mem_lat = 3;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, R + 32'h100, 1'b1);
        chk("redirect_no_req", 128'(o_rv), 128'(0));
        run_until_valid("redirect", 8 - BYP, R + 32'h104);

        // Back-to-back redirects; neither old path may surface.
        do_reset();
        mem_lat = 3;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, R + 32'h200, 1'b1);
        step(1'b0, 1'b1, R + 32'h300, 1'b1);
        run_until_valid("double_redirect", 9 - BYP, R + 32'h304);

        // PC wrap through 2^32.
        mem_lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
        run_until_valid("wrap", -1, 32'hFFFF_FFFC);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Fill the queue under stall, then reset mid-burst.
        do_reset();
        mem_lat = 1;
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("full_before_reset", {126'h0, o_rv, o_vf}, {126'h0, 1'b0, 1'b1});
        do_reset();
        mem_lat = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("restart_addr", {95'h0, o_rv, o_addr}, {95'h0, 1'b1, R});
        run_until_valid("restart", 2 - BYP, R + 32'd4);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            mem_lat = $urandom_range(1, 4);
            st  = ($urandom_range(0, 9) < 3);
            ps  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : R + ($urandom_range(0, 255) << 2);
            step(st, ps, br, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
